// File: rtl/vcr_ovc_alloc_sched.sv
// Output-VC allocator for one router output port: round-robin requester pick, lowest free OVC, credit tracking.
// Build option VCR_OVC_ELIG_FULL_EN: an OVC with zero credits is not offered for allocation.
module vcr_ovc_alloc_sched #(
  parameter int num_vcs   = 4,
  parameter int num_ports = 5,
  parameter int buf_depth = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports*num_vcs-1:0]   req,
  output logic [num_ports*num_vcs-1:0]   gnt,
  output logic [num_vcs-1:0]             gnt_ovc,
  input  logic                           flit_valid,
  input  logic [num_vcs-1:0]             flit_ovc,
  input  logic                           flit_tail,
  input  logic [num_vcs-1:0]             cred_ret,
  output logic [num_vcs-1:0]             ovc_alloc,
  output logic [num_vcs-1:0]             ovc_full,
  output logic [num_vcs-1:0]             ovc_empty
);

  localparam int num_reqs = num_ports * num_vcs;
  localparam int pw = (num_reqs > 1) ? $clog2(num_reqs) : 1;
  localparam int cw = $clog2(buf_depth + 1);
  localparam logic [cw-1:0] cred_max = cw'(buf_depth);
  localparam logic [pw:0]   nr       = (pw+1)'(num_reqs);
  localparam logic [pw-1:0] last_idx = pw'(num_reqs - 1);

  logic [num_vcs-1:0] alloc_p1;
  logic [cw-1:0]      cred_p1 [num_vcs];
  logic [pw-1:0]      ptr_p1;

  logic               req_hit_p0;
  logic [pw-1:0]      req_idx_p0;
  logic [pw:0]        sum_p0;
  logic [num_vcs-1:0] elig_p0;
  logic [num_vcs-1:0] ovc_sel_p0;
  logic               vld_p0;
  logic [pw-1:0]      ptr_nxt_p0;
  logic [num_vcs-1:0] rel_p0;

  // A simultaneous return and departure cancel; otherwise move one step, clamped to [0, buf_depth].
  function automatic logic [cw-1:0] sat_cred(input logic [cw-1:0] c, input logic inc, input logic dec);
    if (inc && !dec) return (c == cred_max) ? c : c + 1'b1;
    if (dec && !inc) return (c == '0) ? c : c - 1'b1;
    return c;
  endfunction

  // Stage p0: combinational requester and OVC selection from registered state
  always_comb begin
    req_hit_p0 = 1'b0;
    req_idx_p0 = '0;
    sum_p0     = '0;
    for (int k = num_reqs - 1; k >= 0; k--) begin
      sum_p0 = {1'b0, ptr_p1} + (pw+1)'(k);
      if (sum_p0 >= nr) sum_p0 = sum_p0 - nr;
      if (req[sum_p0[pw-1:0]]) begin
        req_hit_p0 = 1'b1;
        req_idx_p0 = sum_p0[pw-1:0];
      end
    end
  end

  always_comb begin
    elig_p0    = '0;
    ovc_sel_p0 = '0;
    for (int v = 0; v < num_vcs; v++) begin
`ifdef VCR_OVC_ELIG_FULL_EN
      elig_p0[v] = !alloc_p1[v] && (cred_p1[v] != '0);
`else
      elig_p0[v] = !alloc_p1[v];
`endif
    end
    for (int v = num_vcs - 1; v >= 0; v--) begin
      if (elig_p0[v]) begin
        ovc_sel_p0    = '0;
        ovc_sel_p0[v] = 1'b1;
      end
    end
  end

  // Reset gates the grant so nothing is offered while state is being cleared.
  assign vld_p0     = req_hit_p0 && (|elig_p0) && reset;
  assign ptr_nxt_p0 = (req_idx_p0 == last_idx) ? '0 : req_idx_p0 + 1'b1;
  assign rel_p0     = (flit_valid && flit_tail) ? flit_ovc : '0;
  assign gnt_ovc    = vld_p0 ? ovc_sel_p0 : '0;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < num_reqs; i++) gnt[i] = vld_p0 && (req_idx_p0 == pw'(i));
  end

  // Stage p1: allocation, pointer and credit state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_p1 <= '0;
      ptr_p1   <= '0;
      for (int v = 0; v < num_vcs; v++) cred_p1[v] <= cred_max;
    end else begin
      alloc_p1 <= (alloc_p1 & ~rel_p0) | gnt_ovc;
      if (vld_p0) ptr_p1 <= ptr_nxt_p0;
      for (int v = 0; v < num_vcs; v++)
        cred_p1[v] <= sat_cred(cred_p1[v], cred_ret[v], flit_valid & flit_ovc[v]);
    end
  end

  assign ovc_alloc = alloc_p1;

  always_comb begin
    ovc_full  = '0;
    ovc_empty = '0;
    for (int v = 0; v < num_vcs; v++) begin
      ovc_full[v]  = (cred_p1[v] == '0);
      ovc_empty[v] = (cred_p1[v] == cred_max);
    end
  end

endmodule
